// File: rtl/mem_client_arbiter_if.sv
// Client and memory-side signal bundle for the memory client arbiter.
// The master modport is the arbiter's view; slave is the surrounding system's view.
interface mem_client_arbiter_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_WIDTH  = 42,
  parameter int DATA_WIDTH  = 512,
  localparam int TAG_WIDTH  = $clog2(NUM_CLIENTS)
);
  logic                              buffer_addr_valid;
  logic [NUM_CLIENTS-1:0]            cl_req_valid;
  logic [NUM_CLIENTS-1:0]            cl_req_write;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_req_addr;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_req_data;
  logic [NUM_CLIENTS-1:0]            cl_req_ready;
  logic [NUM_CLIENTS-1:0]            cl_rsp_valid;
  logic [DATA_WIDTH-1:0]             cl_rsp_data;
  logic                              mem_req_valid;
  logic                              mem_req_ready;
  logic                              mem_req_write;
  logic [ADDR_WIDTH-1:0]             mem_req_addr;
  logic [DATA_WIDTH-1:0]             mem_req_data;
  logic [TAG_WIDTH-1:0]              mem_req_tag;
  logic                              mem_rsp_valid;
  logic [TAG_WIDTH-1:0]              mem_rsp_tag;
  logic [DATA_WIDTH-1:0]             mem_rsp_data;
  logic                              err_unexpected_rsp;

  modport master (
    input  buffer_addr_valid, cl_req_valid, cl_req_write, cl_req_addr, cl_req_data,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_tag, mem_rsp_data,
    output cl_req_ready, cl_rsp_valid, cl_rsp_data,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_data, mem_req_tag,
    output err_unexpected_rsp
  );

  modport slave (
    output buffer_addr_valid, cl_req_valid, cl_req_write, cl_req_addr, cl_req_data,
    output mem_req_ready, mem_rsp_valid, mem_rsp_tag, mem_rsp_data,
    input  cl_req_ready, cl_rsp_valid, cl_rsp_data,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_data, mem_req_tag,
    input  err_unexpected_rsp
  );
endinterface

// File: rtl/mem_client_arbiter.sv
// Round-robin N-client front end for a single memory port: one outstanding
// request per client, tag-routed responses, grants gated by buffer_addr_valid.
module mem_client_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_WIDTH  = 42,
  parameter int DATA_WIDTH  = 512,
  localparam int TAG_WIDTH  = $clog2(NUM_CLIENTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_client_arbiter_if.master bus
);
  localparam int N = NUM_CLIENTS;
  localparam logic [TAG_WIDTH-1:0] LAST_IDX = TAG_WIDTH'(NUM_CLIENTS - 1);

  function automatic logic [N-1:0] onehot(input logic [TAG_WIDTH-1:0] idx);
    return N'(1'b1) << idx;
  endfunction

  function automatic logic tag_in_range(input logic [TAG_WIDTH-1:0] t);
    return (int'(t) < NUM_CLIENTS);
  endfunction

  logic [N-1:0]          r_pending;
  logic [TAG_WIDTH-1:0]  r_rr_ptr;
  logic                  r_req_valid;
  logic                  r_req_write;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [DATA_WIDTH-1:0] r_req_data;
  logic [TAG_WIDTH-1:0]  r_req_tag;
  logic [N-1:0]          r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_err;

  logic [N-1:0]          w_eligible;
  logic                  w_load_ok;
  logic                  w_found;
  logic                  w_hit;
  logic [TAG_WIDTH-1:0]  w_cand;
  logic [TAG_WIDTH-1:0]  w_grant_idx;
  logic                  w_grant;
  logic [N-1:0]          w_grant_oh;
  logic                  w_rsp_hit;
  logic [N-1:0]          w_rsp_oh;

  assign w_eligible = bus.cl_req_valid & ~r_pending & {N{bus.buffer_addr_valid}};
  assign w_load_ok  = ~r_req_valid | bus.mem_req_ready;

  // Round-robin search from the pointer; reset also suppresses the grant pulse.
  always_comb begin
    w_found     = 1'b0;
    w_hit       = 1'b0;
    w_cand      = '0;
    w_grant_idx = '0;
    for (int off = 0; off < N; off++) begin
      w_cand      = TAG_WIDTH'((int'(r_rr_ptr) + off) % N);
      w_hit       = ~w_found & w_eligible[w_cand];
      w_grant_idx = w_hit ? w_cand : w_grant_idx;
      w_found     = w_found | w_hit;
    end
    w_grant    = w_found & w_load_ok & ~rst;
    w_grant_oh = w_grant ? onehot(w_grant_idx) : '0;
  end

  // A response is routed only when its tag names a client with a request in flight.
  always_comb begin
    w_rsp_hit = 1'b0;
    w_rsp_oh  = '0;
    if (bus.mem_rsp_valid && tag_in_range(bus.mem_rsp_tag)) begin
      w_rsp_hit = r_pending[bus.mem_rsp_tag];
      w_rsp_oh  = w_rsp_hit ? onehot(bus.mem_rsp_tag) : '0;
    end else begin
      w_rsp_hit = 1'b0;
      w_rsp_oh  = '0;
    end
  end

  // Memory request register: loads on grant, which may coincide with acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_valid <= 1'b0;
      r_req_write <= 1'b0;
      r_req_addr  <= '0;
      r_req_data  <= '0;
      r_req_tag   <= '0;
    end else if (w_grant) begin
      r_req_valid <= 1'b1;
      r_req_write <= bus.cl_req_write[w_grant_idx];
      r_req_addr  <= bus.cl_req_addr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      r_req_data  <= bus.cl_req_data[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
      r_req_tag   <= w_grant_idx;
    end else if (bus.mem_req_ready) begin
      r_req_valid <= 1'b0;
    end
  end

  // Outstanding-request bookkeeping and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_pending <= (r_pending & ~w_rsp_oh) | w_grant_oh;
      if (w_grant) begin
        r_rr_ptr <= (w_grant_idx == LAST_IDX) ? '0 : w_grant_idx + TAG_WIDTH'(1);
      end
    end
  end

  // Registered response delivery and sticky error on stray responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= w_rsp_oh;
      if (w_rsp_hit) begin
        r_rsp_data <= bus.mem_rsp_data;
      end
      r_err <= r_err | (bus.mem_rsp_valid & ~w_rsp_hit);
    end
  end

  assign bus.cl_req_ready       = w_grant_oh;
  assign bus.cl_rsp_valid       = r_rsp_valid;
  assign bus.cl_rsp_data        = r_rsp_data;
  assign bus.mem_req_valid      = r_req_valid;
  assign bus.mem_req_write      = r_req_write;
  assign bus.mem_req_addr       = r_req_addr;
  assign bus.mem_req_data       = r_req_data;
  assign bus.mem_req_tag        = r_req_tag;
  assign bus.err_unexpected_rsp = r_err;
endmodule

// File: tb/tb_mem_client_arbiter.sv
// Directed bench for mem_client_arbiter: a per-cycle reference model of the
// arbitration/response rules plus hand-computed expectations for key scenarios.
module tb_mem_client_arbiter;
  localparam int N  = 4;
  localparam int AW = 42;
  localparam int DW = 512;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_client_arbiter_if #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  mem_client_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [N-1:0]  m_pend;
  int            m_rr;
  logic          m_valid;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_tag;
  logic [N-1:0]  m_rspv;
  logic [DW-1:0] m_rspd;
  logic          m_err;

  // outputs observed at the last negedge sample
  logic [N-1:0]  obs_ready;
  logic          obs_mvalid;
  logic          obs_mwrite;
  logic [AW-1:0] obs_maddr;
  logic [TW-1:0] obs_mtag;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_rr = 0; m_valid = 1'b0; m_write = 1'b0; m_addr = '0;
    m_data = '0; m_tag = 0; m_rspv = '0; m_rspd = '0; m_err = 1'b0;
  endtask

  // Compare every output against the model, then advance the model one clock.
  task automatic model_cycle();
    int g;
    logic [N-1:0] exp_ready;
    obs_ready  = bus.cl_req_ready;
    obs_mvalid = bus.mem_req_valid;
    obs_mwrite = bus.mem_req_write;
    obs_maddr  = bus.mem_req_addr;
    obs_mtag   = bus.mem_req_tag;
    if (rst) model_reset();
    g = -1;
    if (!rst && bus.buffer_addr_valid && (!m_valid || bus.mem_req_ready)) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (g < 0 && bus.cl_req_valid[c] && !m_pend[c]) g = c;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("m_cl_req_ready", DW'(bus.cl_req_ready), DW'(exp_ready));
    chk("m_mem_req_valid", DW'(bus.mem_req_valid), DW'(m_valid));
    if (m_valid) begin
      chk("m_mem_req_write", DW'(bus.mem_req_write), DW'(m_write));
      chk("m_mem_req_addr", DW'(bus.mem_req_addr), DW'(m_addr));
      chk("m_mem_req_data", bus.mem_req_data, m_data);
      chk("m_mem_req_tag", DW'(bus.mem_req_tag), DW'(m_tag));
    end
    chk("m_cl_rsp_valid", DW'(bus.cl_rsp_valid), DW'(m_rspv));
    chk("m_cl_rsp_data", bus.cl_rsp_data, m_rspd);
    chk("m_err", DW'(bus.err_unexpected_rsp), DW'(m_err));
    if (rst) return;
    m_rspv = '0;
    if (bus.mem_rsp_valid) begin
      if (int'(bus.mem_rsp_tag) < N && m_pend[bus.mem_rsp_tag]) begin
        m_rspv[bus.mem_rsp_tag] = 1'b1;
        m_rspd = bus.mem_rsp_data;
        m_pend[bus.mem_rsp_tag] = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    if (g >= 0) begin
      m_valid = 1'b1;
      m_write = bus.cl_req_write[g];
      m_addr  = bus.cl_req_addr[g*AW +: AW];
      m_data  = bus.cl_req_data[g*DW +: DW];
      m_tag   = g;
      m_pend[g] = 1'b1;
      m_rr = (g + 1) % N;
    end else if (bus.mem_req_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rsp(input logic v, input int tag, input logic [DW-1:0] d);
    bus.mem_rsp_valid = v;
    bus.mem_rsp_tag   = TW'(tag);
    bus.mem_rsp_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    bus.buffer_addr_valid = 1'b0;
    bus.cl_req_valid = '0;
    bus.cl_req_write = '0;
    bus.cl_req_addr  = '0;
    bus.cl_req_data  = '0;
    bus.mem_req_ready = 1'b0;
    rsp(1'b0, 0, '0);
    model_reset();
    for (int i = 0; i < N; i++) begin
      bus.cl_req_addr[i*AW +: AW] = AW'(42'h1000 + 42'(i) * 42'h40);
      bus.cl_req_data[i*DW +: DW] = DW'(32'hC0DE0000 + 32'(i));
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("t1_idle_mem_req_valid", DW'(bus.mem_req_valid), DW'(1'b0));
    chk("t1_idle_rsp_valid", DW'(bus.cl_rsp_valid), DW'(4'b0000));
    chk("t1_idle_err", DW'(bus.err_unexpected_rsp), DW'(1'b0));

    // 1: all clients requesting but no buffer address -> no grant
    bus.cl_req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t1_gated_ready", DW'(obs_ready), DW'(4'b0000));
    end

    // 2: round robin 0,1,2,3 back to back
    bus.buffer_addr_valid = 1'b1;
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      tick();
      chk("t2_grant", DW'(obs_ready), DW'(4'b0001 << i));
      if (i > 0) chk("t2_tag", DW'(obs_mtag), DW'(i - 1));
    end
    tick();
    chk("t2_tag_last", DW'(obs_mtag), DW'(3));
    chk("t2_no_more_ready", DW'(obs_ready), DW'(4'b0000));
    bus.cl_req_valid = 4'b0000;

    // 4: response for client 1; same-cycle request must wait a cycle
    rsp(1'b1, 1, DW'(16'hDEAD));
    bus.cl_req_valid = 4'b0010;
    tick();
    chk("t4_same_cycle_ready", DW'(obs_ready), DW'(4'b0000));
    chk("t4_rsp_valid", DW'(bus.cl_rsp_valid), DW'(4'b0010));
    chk("t4_rsp_data", bus.cl_rsp_data, DW'(16'hDEAD));
    rsp(1'b0, 0, '0);
    tick();
    chk("t4_regrant", DW'(obs_ready), DW'(4'b0010));
    bus.cl_req_valid = 4'b0000;

    // 3: free clients 2 and 0, then hold client 2's write under backpressure
    rsp(1'b1, 2, '0);
    tick();
    rsp(1'b1, 0, '0);
    tick();
    rsp(1'b0, 0, '0);
    bus.cl_req_valid = 4'b0100;
    bus.cl_req_write = 4'b0100;
    bus.cl_req_addr[2*AW +: AW] = AW'(12'h100);
    bus.cl_req_data[2*DW +: DW] = DW'(16'h5A5A);
    bus.mem_req_ready = 1'b0;
    tick();
    chk("t3_grant2", DW'(obs_ready), DW'(4'b0100));
    bus.cl_req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_stall_ready", DW'(obs_ready), DW'(4'b0000));
      chk("t3_stall_valid", DW'(obs_mvalid), DW'(1'b1));
      chk("t3_stall_addr", DW'(obs_maddr), DW'(12'h100));
      chk("t3_stall_write", DW'(obs_mwrite), DW'(1'b1));
      chk("t3_stall_tag", DW'(obs_mtag), DW'(2));
      chk("t3_stall_data", bus.mem_req_data, DW'(16'h5A5A));
    end
    bus.mem_req_ready = 1'b1;
    tick();
    chk("t3_back_to_back", DW'(obs_ready), DW'(4'b0001));
    bus.cl_req_valid = 4'b0000;
    tick();
    chk("t3_next_tag", DW'(obs_mtag), DW'(0));
    tick();

    // 5: legitimate response on tag 3, then a stray one
    rsp(1'b1, 3, DW'(16'hBEEF));
    tick();
    chk("t5_first_rsp", DW'(bus.cl_rsp_valid), DW'(4'b1000));
    chk("t5_first_err", DW'(bus.err_unexpected_rsp), DW'(1'b0));
    tick();
    chk("t5_stray_rsp", DW'(bus.cl_rsp_valid), DW'(4'b0000));
    chk("t5_stray_err", DW'(bus.err_unexpected_rsp), DW'(1'b1));
    rsp(1'b0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_err_sticky", DW'(bus.err_unexpected_rsp), DW'(1'b1));
    end

    // 6: reset with requests in flight, then an old-tag response
    bus.cl_req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    chk("t6_rst_mem_valid", DW'(bus.mem_req_valid), DW'(1'b0));
    chk("t6_rst_ready", DW'(bus.cl_req_ready), DW'(4'b0000));
    chk("t6_rst_rsp_valid", DW'(bus.cl_rsp_valid), DW'(4'b0000));
    chk("t6_rst_err", DW'(bus.err_unexpected_rsp), DW'(1'b0));
    chk("t6_rst_rsp_data", bus.cl_rsp_data, DW'(1'b0));
    tick();
    rst = 1'b0;
    bus.cl_req_valid = 4'b0000;
    tick();
    rsp(1'b1, 1, DW'(16'h1234));
    tick();
    chk("t6_old_tag_err", DW'(bus.err_unexpected_rsp), DW'(1'b1));
    chk("t6_old_tag_rsp", DW'(bus.cl_rsp_valid), DW'(4'b0000));
    rsp(1'b0, 0, '0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
